// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for the dmem responder
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Register offsets relative to the start of the MMIO block
  localparam logic [31:0] OFF_CYCLE = 32'h0000_0000;
  localparam logic [31:0] OFF_LED   = 32'h0000_0004;
  localparam logic [31:0] OFF_ERR   = 32'h0000_0008;

  localparam int ERR_ALIGN = 0;
  localparam int ERR_UNMAP = 1;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_CYCLE,
    RGN_LED,
    RGN_ERR,
    RGN_NONE
  } region_e;

endpackage

// File: rtl/dmem_lane_unit.sv
// rtl/dmem_lane_unit.sv - little-endian byte/half lane merge and extract
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] store_word_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel     = word_i[{lane_i, 3'b000} +: 8];
    half_sel     = lane_i[1] ? word_i[31:16] : word_i[15:0];
    store_word_o = word_i;
    load_data_o  = 32'h0;
    misalign_o   = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        store_word_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
        load_data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        misalign_o = lane_i[0];
        if (lane_i[1]) store_word_o[31:16] = wdata_i[15:0];
        else           store_word_o[15:0]  = wdata_i[15:0];
        load_data_o = {{16{sign_i & half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        misalign_o   = |lane_i;
        store_word_o = wdata_i;
        load_data_o  = word_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data RAM plus cycle/LED/error MMIO on the CPU dmem bus
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'h1001_0000,
  parameter int          ADDR_W   = 11,
  parameter logic [31:0] MMIO_OFF = 32'h0000_FF00,
  parameter int          LED_W    = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [31:0]      dmem_addr,
  input  logic [31:0]      dmem_data,
  input  logic             dmem_we,
  input  logic [1:0]       dmem_size,
  input  logic             dmem_sign,
  output logic [31:0]      dmem_out,
  output logic [LED_W-1:0] led,
  output logic [1:0]       err
);

  localparam int          DEPTH     = 2 ** ADDR_W;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       cycle_q, cycle_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [1:0]        err_q, err_d;

  logic [31:0]       off;
  logic [ADDR_W-1:0] idx;
  region_e           rgn;
  logic [31:0]       ram_word, store_word, lane_load;
  logic              misalign, mapped, fault, ram_we;

  assign off      = dmem_addr - BASE;
  assign idx      = off[ADDR_W+1:2];
  assign ram_word = mem_q[idx];

  always_comb begin
    rgn = RGN_NONE;
    if (off < RAM_BYTES)                   rgn = RGN_RAM;
    else if (off == MMIO_OFF + OFF_CYCLE)  rgn = RGN_CYCLE;
    else if (off == MMIO_OFF + OFF_LED)    rgn = RGN_LED;
    else if (off == MMIO_OFF + OFF_ERR)    rgn = RGN_ERR;
  end

  dmem_lane_unit u_lane (
    .word_i       (ram_word),
    .wdata_i      (dmem_data),
    .lane_i       (dmem_addr[1:0]),
    .size_i       (dmem_size),
    .sign_i       (dmem_sign),
    .store_word_o (store_word),
    .load_data_o  (lane_load),
    .misalign_o   (misalign)
  );

  // MMIO registers only accept whole-word accesses
  assign mapped = (rgn != RGN_NONE);
  assign fault  = misalign | (mapped && rgn != RGN_RAM && dmem_size != SZ_WORD);
  assign ram_we = dmem_we && rgn == RGN_RAM && !fault;

  always_comb begin
    dmem_out = 32'h0;
    if (!fault) begin
      case (rgn)
        RGN_RAM:   dmem_out = lane_load;
        RGN_CYCLE: dmem_out = cycle_q;
        RGN_LED:   dmem_out = 32'(led_q);
        RGN_ERR:   dmem_out = {30'b0, err_q};
        default:   dmem_out = 32'h0;
      endcase
    end
  end

  // Loads only flag alignment on mapped addresses: non-memory instructions drive junk
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    led_d   = led_q;
    err_d   = err_q;
    if (dmem_we) begin
      if (fault) err_d[ERR_ALIGN] = 1'b1;
      if (!mapped) begin
        err_d[ERR_UNMAP] = 1'b1;
      end else if (!fault) begin
        case (rgn)
          RGN_LED: led_d = dmem_data[LED_W-1:0];
          RGN_ERR: err_d = 2'b00;
          default: ;
        endcase
      end
    end else if (fault && mapped) begin
      err_d[ERR_ALIGN] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cycle_q <= 32'h0;
      led_q   <= '0;
      err_q   <= 2'b00;
    end else begin
      cycle_q <= cycle_d;
      led_q   <= led_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) mem_q[idx] <= store_word;
  end

  assign led = led_q;
  assign err = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam logic [1:0]  SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dmem_addr = BASE, dmem_data = 32'h0;
  logic        dmem_we = 1'b0;
  logic [1:0]  dmem_size = SW;
  logic        dmem_sign = 1'b0;
  logic [31:0] dmem_out;
  logic [15:0] led;
  logic [1:0]  err;

  int total = 0;
  int bad = 0;

  int unsigned model_cyc;
  logic [7:0]  mb [0:8191];
  logic [15:0] m_led;
  logic [1:0]  m_err;

  always #5 clk_in = ~clk_in;

  dmem_responder dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .dmem_addr (dmem_addr),
    .dmem_data (dmem_data),
    .dmem_we   (dmem_we),
    .dmem_size (dmem_size),
    .dmem_sign (dmem_sign),
    .dmem_out  (dmem_out),
    .led       (led),
    .err       (err)
  );

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic [1:0] sz, input logic sg);
    dmem_addr = a; dmem_data = d; dmem_we = we; dmem_size = sz; dmem_sign = sg;
    #1;
  endtask

  task automatic idle();
    drive(BASE, 32'h0, 1'b0, SW, 1'b0);
  endtask

  task automatic step();
    @(posedge clk_in);
    if (!reset) model_cyc++;
    @(negedge clk_in);
  endtask

  // 0 ram, 1 cycle, 2 led, 3 err, 4 unmapped
  function automatic int region(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    if (o < 32'd8192) return 0;
    if (o == 32'hFF00) return 1;
    if (o == 32'hFF04) return 2;
    if (o == 32'hFF08) return 3;
    return 4;
  endfunction

  function automatic bit is_fault(input logic [31:0] a, input logic [1:0] sz);
    int r;
    bit f;
    r = region(a);
    case (sz)
      SB: f = 1'b0;
      SH: f = a[0];
      SW: f = (a[1:0] != 2'b00);
      default: f = 1'b1;
    endcase
    if (r >= 1 && r <= 3 && sz != SW) f = 1'b1;
    return f;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic sg);
    int r;
    int unsigned o;
    logic [31:0] v;
    r = region(a);
    o = a - BASE;
    if (is_fault(a, sz) || r == 4) return 32'h0;
    if (r == 1) return model_cyc;
    if (r == 2) return {16'h0, m_led};
    if (r == 3) return {30'h0, m_err};
    if (sz == SB) begin
      v = {24'h0, mb[o]};
      if (sg && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == SH) begin
      v = {16'h0, mb[o+1], mb[o]};
      if (sg && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = {mb[o+3], mb[o+2], mb[o+1], mb[o]};
    end
    return v;
  endfunction

  task automatic model_commit(input logic [31:0] a, input logic [31:0] d, input logic we,
                              input logic [1:0] sz);
    int r;
    int unsigned o;
    bit f;
    r = region(a);
    o = a - BASE;
    f = is_fault(a, sz);
    if (we) begin
      if (f) m_err[0] = 1'b1;
      if (r == 4) m_err[1] = 1'b1;
      else if (!f) begin
        if (r == 0) for (int i = 0; i < (1 << sz); i++) mb[o+i] = d[8*i +: 8];
        if (r == 2) m_led = d[15:0];
        if (r == 3) m_err = 2'b00;
      end
    end else if (f && r != 4) begin
      m_err[0] = 1'b1;
    end
  endtask

  task automatic test_reset();
    idle();
    repeat (3) @(negedge clk_in);
    total++; if (led !== 16'h0) begin bad++; $display("FAIL rst_led: got %h want 0000", led); end
    total++; if (err !== 2'b00) begin bad++; $display("FAIL rst_err: got %b want 00", err); end
    drive(32'h1001_FF00, 32'h0, 1'b0, SW, 1'b0);
    total++; if (dmem_out !== 32'h0) begin bad++; $display("FAIL rst_cyc_read: got %h want 0", dmem_out); end
    reset = 1'b0;
    model_cyc = 0;
    idle();
    repeat (5) step();
    drive(32'h1001_FF00, 32'h0, 1'b0, SW, 1'b0);
    total++; if (dmem_out !== model_cyc || model_cyc != 5)
      begin bad++; $display("FAIL cyc_after5: got %h want %h", dmem_out, model_cyc); end
    step();
  endtask

  task automatic test_byte_lanes();
    drive(32'h1001_0008, 32'h1122_3344, 1'b1, SW, 1'b0); step();
    drive(32'h1001_000A, 32'hFFFF_FFAA, 1'b1, SB, 1'b0); step();
    drive(32'h1001_0008, 32'h0, 1'b0, SW, 1'b0);
    total++; if (dmem_out !== 32'h11AA_3344) begin bad++; $display("FAIL sb_merge: got %h want 11aa3344", dmem_out); end
    drive(32'h1001_000A, 32'h0, 1'b0, SB, 1'b1);
    total++; if (dmem_out !== 32'hFFFF_FFAA) begin bad++; $display("FAIL lb: got %h want ffffffaa", dmem_out); end
    drive(32'h1001_000A, 32'h0, 1'b0, SB, 1'b0);
    total++; if (dmem_out !== 32'h0000_00AA) begin bad++; $display("FAIL lbu: got %h want 000000aa", dmem_out); end
    drive(32'h1001_0008, 32'h0102_0304, 1'b1, SW, 1'b0);
    total++; if (dmem_out !== 32'h11AA_3344) begin bad++; $display("FAIL rdw_old: got %h want 11aa3344", dmem_out); end
    step();
    drive(32'h1001_0008, 32'h0, 1'b0, SW, 1'b0);
    total++; if (dmem_out !== 32'h0102_0304) begin bad++; $display("FAIL rdw_new: got %h want 01020304", dmem_out); end
    step();
  endtask

  task automatic test_half_lanes();
    drive(32'h1001_0010, 32'h0000_CAFE, 1'b1, SW, 1'b0); step();
    drive(32'h1001_0012, 32'h1234_8001, 1'b1, SH, 1'b0); step();
    drive(32'h1001_0012, 32'h0, 1'b0, SH, 1'b1);
    total++; if (dmem_out !== 32'hFFFF_8001) begin bad++; $display("FAIL lh: got %h want ffff8001", dmem_out); end
    drive(32'h1001_0012, 32'h0, 1'b0, SH, 1'b0);
    total++; if (dmem_out !== 32'h0000_8001) begin bad++; $display("FAIL lhu: got %h want 00008001", dmem_out); end
    drive(32'h1001_0010, 32'h0, 1'b0, SW, 1'b0);
    total++; if (dmem_out !== 32'h8001_CAFE) begin bad++; $display("FAIL sh_merge: got %h want 8001cafe", dmem_out); end
    step();
  endtask

  task automatic test_errors();
    drive(32'h1001_0004, 32'h5566_7788, 1'b1, SW, 1'b0); step();
    drive(32'h1001_0005, 32'h1234_5678, 1'b1, SW, 1'b0);
    total++; if (dmem_out !== 32'h0) begin bad++; $display("FAIL fault_out: got %h want 0", dmem_out); end
    step();
    total++; if (err !== 2'b01) begin bad++; $display("FAIL err_align: got %b want 01", err); end
    drive(32'h1001_0004, 32'h0, 1'b0, SW, 1'b0);
    total++; if (dmem_out !== 32'h5566_7788) begin bad++; $display("FAIL misal_dropped: got %h want 55667788", dmem_out); end
    step();
    drive(32'h1002_0000, 32'h0, 1'b1, SW, 1'b0); step();
    total++; if (err !== 2'b11) begin bad++; $display("FAIL err_unmap: got %b want 11", err); end
    drive(32'h1001_FF08, 32'h0, 1'b0, SW, 1'b0);
    total++; if (dmem_out !== 32'h3) begin bad++; $display("FAIL err_read: got %h want 3", dmem_out); end
    drive(32'h1001_FF08, 32'hFFFF_FFFF, 1'b1, SW, 1'b0); step();
    total++; if (err !== 2'b00) begin bad++; $display("FAIL err_clear: got %b want 00", err); end
    drive(32'h1003_0001, 32'h0, 1'b0, SW, 1'b0);
    total++; if (dmem_out !== 32'h0) begin bad++; $display("FAIL unmap_load: got %h want 0", dmem_out); end
    step();
    total++; if (err !== 2'b00) begin bad++; $display("FAIL unmap_load_noerr: got %b want 00", err); end
    drive(32'h1001_FF04, 32'h0, 1'b0, SB, 1'b0); step();
    total++; if (err !== 2'b01) begin bad++; $display("FAIL mmio_byte_load: got %b want 01", err); end
    drive(32'h1001_FF08, 32'h0, 1'b1, SW, 1'b0); step();
    idle();
  endtask

  task automatic test_led_cycle();
    drive(32'h1001_FF04, 32'hDEAD_BEEF, 1'b1, SW, 1'b0); step();
    total++; if (led !== 16'hBEEF) begin bad++; $display("FAIL led_out: got %h want beef", led); end
    drive(32'h1001_FF04, 32'h0, 1'b0, SW, 1'b0);
    total++; if (dmem_out !== 32'h0000_BEEF) begin bad++; $display("FAIL led_read: got %h want 0000beef", dmem_out); end
    drive(32'h1001_FF00, 32'h0000_0000, 1'b1, SW, 1'b0); step();
    drive(32'h1001_FF00, 32'h0, 1'b0, SW, 1'b0);
    total++; if (dmem_out !== model_cyc) begin bad++; $display("FAIL cyc_write_drop: got %h want %h", dmem_out, model_cyc); end
    total++; if (err !== 2'b00) begin bad++; $display("FAIL cyc_write_noerr: got %b want 00", err); end
    step();
  endtask

  task automatic test_wrap_and_reset();
    drive(32'h1002_0000, 32'h0, 1'b1, SW, 1'b0); step();
    drive(32'h1001_FF00, 32'h0, 1'b0, SW, 1'b0);
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_q;
    #1;
    total++; if (dmem_out !== 32'hFFFF_FFFE) begin bad++; $display("FAIL cyc_deposit: got %h want fffffffe", dmem_out); end
    step();
    total++; if (dmem_out !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cyc_max: got %h want ffffffff", dmem_out); end
    step();
    total++; if (dmem_out !== 32'h0) begin bad++; $display("FAIL cyc_wrap: got %h want 0", dmem_out); end
    step();
    total++; if (dmem_out !== 32'h1) begin bad++; $display("FAIL cyc_wrap1: got %h want 1", dmem_out); end
    #1 reset = 1'b1;
    #1;
    total++; if (dmem_out !== 32'h0) begin bad++; $display("FAIL async_cyc: got %h want 0", dmem_out); end
    total++; if (led !== 16'h0) begin bad++; $display("FAIL async_led: got %h want 0", led); end
    total++; if (err !== 2'b00) begin bad++; $display("FAIL async_err: got %b want 00", err); end
    @(negedge clk_in);
    reset = 1'b0;
    model_cyc = 0;
    m_led = 16'h0;
    m_err = 2'b00;
    idle();
  endtask

  task automatic test_random();
    logic [31:0] a, d, e;
    logic we, sg;
    logic [1:0] sz;
    int r, s;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      drive(BASE + 32'h100 + 32'(4 * i), d, 1'b1, SW, 1'b0); step();
      model_commit(BASE + 32'h100 + 32'(4 * i), d, 1'b1, SW);
    end
    d = $urandom;
    drive(BASE + 32'h1FFC, d, 1'b1, SW, 1'b0); step();
    model_commit(BASE + 32'h1FFC, d, 1'b1, SW);
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      a = BASE + 32'h100 + 32'($urandom_range(0, 63));
      else if (r < 85) a = BASE + 32'hFF00 + 32'($urandom_range(0, 12));
      else if (r < 95) a = ($urandom_range(0, 1) == 0) ? BASE + 32'h2000 + 32'($urandom_range(0, 255))
                                                       : BASE - 32'($urandom_range(1, 8));
      else             a = BASE + 32'h1FFC + 32'($urandom_range(0, 3));
      s  = $urandom_range(0, 9);
      sz = (s < 3) ? SB : (s < 6) ? SH : (s < 9) ? SW : SX;
      we = ($urandom_range(0, 2) == 0);
      sg = $urandom_range(0, 1) == 1;
      d  = $urandom;
      drive(a, d, we, sz, sg);
      e = exp_load(a, sz, sg);
      total++; if (dmem_out !== e) begin bad++; $display("FAIL rnd_out a=%h sz=%0d: got %h want %h", a, sz, dmem_out, e); end
      step();
      model_commit(a, d, we, sz);
      total++; if (err !== m_err) begin bad++; $display("FAIL rnd_err a=%h: got %b want %b", a, err, m_err); end
      total++; if (led !== m_led) begin bad++; $display("FAIL rnd_led a=%h: got %h want %h", a, led, m_led); end
    end
    idle();
  endtask

  initial begin
    model_cyc = 0;
    m_led = 16'h0;
    m_err = 2'b00;
    test_reset();
    test_byte_lanes();
    test_half_lanes();
    test_errors();
    test_led_cycle();
    test_wrap_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
